// File: rtl/sid_i2s_tx_if.sv
// +------------------------------------------------------------------+
// | sid_i2s_tx_if : sample-in / I2S-out signal bundle for sid_i2s_tx |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface sid_i2s_tx_if;
  logic        sample_valid;
  logic [23:0] left_i;
  logic [23:0] right_i;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic        underrun;
  logic        overrun;

  modport master (
    output sample_valid, left_i, right_i,
    input  i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun
  );

  modport slave (
    input  sample_valid, left_i, right_i,
    output i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun
  );
endinterface

`default_nettype wire

// File: rtl/sid_i2s_tx.sv
// +------------------------------------------------------------------+
// | sid_i2s_tx : double-buffered Philips I2S transmitter, 64 BCLK    |
// | frames. Optional TPDF-style LFSR dither: SID_I2S_DITHER_EN.      |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module sid_i2s_tx #(
  parameter int CLK_DIV  = 4,
  parameter int OUT_BITS = 24
) (
  input  wire logic    clk,
  input  wire logic    rst,
  sid_i2s_tx_if.slave  bus
);

  localparam int          DIV_W     = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [31:0] SLOT_MASK = ~(32'hFFFF_FFFF >> OUT_BITS);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             sdata_q, sdata_d;
  logic [5:0]       bit_cnt_q, bit_cnt_d;
  logic [63:0]      frame_q, frame_d;
  logic [23:0]      hold_l_q, hold_l_d;
  logic [23:0]      hold_r_q, hold_r_d;
  logic             pending_q, pending_d;
  logic             underrun_q, underrun_d;
  logic             overrun_q, overrun_d;

  logic [23:0]      w_left;
  logic [23:0]      w_right;
  logic [31:0]      w_lslot;
  logic [30:0]      w_rslot_hi;
  logic             w_fall;
  logic             w_load;

`ifdef SID_I2S_DITHER_EN
  localparam logic [23:0] DITH_MASK = 24'((25'd1 << (24 - OUT_BITS)) - 25'd1);

  logic [15:0] lfsr_q, lfsr_d;
  logic [23:0] w_dith;

  // Dither is unsigned, so only positive overflow is possible.
  function automatic logic [23:0] sat_add(input logic [23:0] s, input logic [23:0] d);
    logic [24:0] sum;
    sum = {s[23], s} + {1'b0, d};
    return (sum[24] != sum[23]) ? 24'h7F_FFFF : sum[23:0];
  endfunction

  assign w_dith  = {8'h00, lfsr_q} & DITH_MASK;
  assign w_left  = sat_add(bus.left_i, w_dith);
  assign w_right = sat_add(bus.right_i, w_dith);

  always_comb begin
    lfsr_d = lfsr_q;
    if (bus.sample_valid) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end
`else
  assign w_left  = bus.left_i;
  assign w_right = bus.right_i;
`endif

  // Slots are MSB-aligned; the right slot LSB is always zero and is dropped.
  assign w_lslot    = {hold_l_q, 8'h00} & SLOT_MASK;
  assign w_rslot_hi = {hold_r_q, 7'h00} & SLOT_MASK[31:1];

  always_comb begin
    div_cnt_d  = div_cnt_q + DIV_W'(1);
    bclk_d     = bclk_q;
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;
    pending_d  = pending_q;
    underrun_d = 1'b0;
    overrun_d  = 1'b0;
    w_fall     = 1'b0;
    w_load     = 1'b0;

    if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
      w_fall    = bclk_q;
    end

    if (w_fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrclk_d   = bit_cnt_d[5];
      if (bit_cnt_q == 6'd63) begin
        w_load     = 1'b1;
        frame_d    = {1'b0, w_lslot, w_rslot_hi};
        pending_d  = 1'b0;
        underrun_d = ~pending_q;
      end
      sdata_d = frame_d[6'd63 - bit_cnt_d];
    end

    // A sample arriving on the load cycle is queued for the following frame.
    if (bus.sample_valid) begin
      hold_l_d  = w_left;
      hold_r_d  = w_right;
      pending_d = 1'b1;
      overrun_d = pending_q & ~w_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      bclk_q     <= 1'b0;
      lrclk_q    <= 1'b1;
      sdata_q    <= 1'b0;
      bit_cnt_q  <= 6'd63;
      frame_q    <= '0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
      pending_q  <= 1'b0;
      underrun_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bclk_q     <= bclk_d;
      lrclk_q    <= lrclk_d;
      sdata_q    <= sdata_d;
      bit_cnt_q  <= bit_cnt_d;
      frame_q    <= frame_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
      pending_q  <= pending_d;
      underrun_q <= underrun_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.i2s_bclk  = bclk_q;
  assign bus.i2s_lrclk = lrclk_q;
  assign bus.i2s_sdata = sdata_q;
  assign bus.underrun  = underrun_q;
  assign bus.overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_sid_i2s_tx.sv
// +------------------------------------------------------------------+
// | tb_sid_i2s_tx : bench for sid_i2s_tx, 24-bit and 16-bit builds   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sid_i2s_tx;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = 128 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sv  = 1'b0;
  logic [23:0] lin = '0;
  logic [23:0] rin = '0;

  always #5 clk = ~clk;

  sid_i2s_tx_if if_a ();
  sid_i2s_tx_if if_b ();

  assign if_a.sample_valid = sv;
  assign if_a.left_i       = lin;
  assign if_a.right_i      = rin;
  assign if_b.sample_valid = sv;
  assign if_b.left_i       = lin;
  assign if_b.right_i      = rin;

  sid_i2s_tx #(.CLK_DIV(CLK_DIV), .OUT_BITS(24)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  sid_i2s_tx #(.CLK_DIV(CLK_DIV), .OUT_BITS(16)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  logic o_bclk[2], o_lr[2], o_sd[2], o_ur[2], o_ov[2];
  assign o_bclk[0] = if_a.i2s_bclk;  assign o_bclk[1] = if_b.i2s_bclk;
  assign o_lr[0]   = if_a.i2s_lrclk; assign o_lr[1]   = if_b.i2s_lrclk;
  assign o_sd[0]   = if_a.i2s_sdata; assign o_sd[1]   = if_b.i2s_sdata;
  assign o_ur[0]   = if_a.underrun;  assign o_ur[1]   = if_b.underrun;
  assign o_ov[0]   = if_a.overrun;   assign o_ov[1]   = if_b.overrun;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int obits(input int d);
    return (d == 0) ? 24 : 16;
  endfunction

  // ---------------- behavioural model ----------------
  function automatic bit slot_bit(input logic [23:0] s, input int ob, input int j);
    logic [23:0] t;
    t = s;
    if (j >= 32 - ob) return t[j-8];
    return 1'b0;
  endfunction

  // Bit transmitted at frame position pos (0 = LRCLK-low edge)
  function automatic bit frame_bit(input logic [23:0] l, input logic [23:0] r, input int ob, input int pos);
    if (pos == 0)  return 1'b0;
    if (pos <= 32) return slot_bit(l, ob, 32 - pos);
    return slot_bit(r, ob, 64 - pos);
  endfunction

  function automatic logic [23:0] cond(input logic [23:0] s, input int ob, input logic [15:0] lf);
`ifdef SID_I2S_DITHER_EN
    int dv;
    int v;
    dv = int'(lf) % (1 << (24 - ob));
    v  = int'($signed(s)) + dv;
    if (v > 8388607) return 24'h7F_FFFF;
    return v[23:0];
`else
    return s;
`endif
  endfunction

  int          k;
  bit          m_valid = 1'b0;
  logic [23:0] hl[2], hr[2], fl[2], fr[2];
  bit          pend[2];
  bit          e_bclk;
  bit          e_lr[2], e_sd[2], e_ur[2], e_or[2];
  logic [15:0] m_lfsr;

  always @(posedge clk) begin
    bit fall, load, pold;
    int pos;
    if (rst) begin
      k = 0; m_valid = 1'b1; m_lfsr = 16'hACE1; e_bclk = 1'b0;
      for (int d = 0; d < 2; d++) begin
        hl[d] = '0; hr[d] = '0; fl[d] = '0; fr[d] = '0; pend[d] = 1'b0;
        e_lr[d] = 1'b1; e_sd[d] = 1'b0; e_ur[d] = 1'b0; e_or[d] = 1'b0;
      end
    end else begin
      k++;
      e_bclk = ((k / CLK_DIV) % 2) == 1;
      fall   = (k % (2 * CLK_DIV)) == 0;
      pos    = (k / (2 * CLK_DIV) + 63) % 64;
      load   = fall && (pos == 0);
      for (int d = 0; d < 2; d++) begin
        pold = pend[d];
        e_ur[d] = 1'b0;
        e_or[d] = 1'b0;
        if (load) begin
          fl[d] = hl[d]; fr[d] = hr[d];
          e_ur[d] = !pold;
          pend[d] = 1'b0;
        end
        if (fall) begin
          e_lr[d] = (pos >= 32);
          e_sd[d] = frame_bit(fl[d], fr[d], obits(d), pos);
        end
        if (sv) begin
          e_or[d] = pold && !load;
          hl[d] = cond(lin, obits(d), m_lfsr);
          hr[d] = cond(rin, obits(d), m_lfsr);
          pend[d] = 1'b1;
        end
      end
      if (sv) m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      for (int d = 0; d < 2; d++) begin
        chk("bclk",     d, 64'(o_bclk[d]), 64'(e_bclk));
        chk("lrclk",    d, 64'(o_lr[d]),   64'(e_lr[d]));
        chk("sdata",    d, 64'(o_sd[d]),   64'(e_sd[d]));
        chk("underrun", d, 64'(o_ur[d]),   64'(e_ur[d]));
        chk("overrun",  d, 64'(o_ov[d]),   64'(e_or[d]));
      end
    end
  end

  // ---------------- serial frame capture ----------------
  logic [63:0] cur[2], last_fr[2];
  int          nbits[2] = '{0, 0};
  int          nfr[2]   = '{0, 0};
  int          novr[2]  = '{0, 0};
  bit          pb[2]    = '{0, 0};
  bit          pl[2]    = '{1, 1};

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        nbits[d] = 0; pb[d] = 1'b0; pl[d] = 1'b1;
      end else begin
        if (pb[d] && !o_bclk[d]) begin
          if (pl[d] && !o_lr[d]) begin
            if (nbits[d] == 64) begin
              last_fr[d] = cur[d];
              nfr[d]++;
            end
            cur[d]   = {63'b0, o_sd[d]};
            nbits[d] = 1;
          end else begin
            cur[d] = {cur[d][62:0], o_sd[d]};
            if (nbits[d] < 64) nbits[d]++;
          end
        end
        if (o_ov[d]) novr[d]++;
        pb[d] = o_bclk[d];
        pl[d] = o_lr[d];
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [23:0] l, input logic [23:0] r, input int phase);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((k % FRAME) != phase && n < FRAME + 4);
    if ((k % FRAME) != phase) begin
      n_tests++; n_fail++;
      $display("FAIL send_phase: got %0d expected %0d", k % FRAME, phase);
    end
    sv = 1'b1; lin = l; rin = r;
    @(negedge clk);
    sv = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (nfr[0] < target && n < 3 * FRAME) begin
      @(posedge clk);
      n++;
    end
    if (nfr[0] < target) begin
      n_tests++; n_fail++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", nfr[0], target);
    end
  endtask

  task automatic chk_frame(input string nm, input int d, input logic [31:0] el, input logic [31:0] er);
    chk({nm, "_left"},  d, 64'(last_fr[d][62:31]),      64'(el));
    chk({nm, "_right"}, d, 64'({last_fr[d][30:0], 1'b0}), 64'(er));
    chk({nm, "_bit0"},  d, 64'(last_fr[d][63]),         64'd0);
  endtask

  int f0;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_bclk",  d, 64'(o_bclk[d]), 64'd0);
      chk("rst_lrclk", d, 64'(o_lr[d]),   64'd1);
      chk("rst_sdata", d, 64'(o_sd[d]),   64'd0);
      chk("rst_ur",    d, 64'(o_ur[d]),   64'd0);
      chk("rst_ov",    d, 64'(o_ov[d]),   64'd0);
    end
    rst = 1'b0;

    // Extreme values, MSB-first framing with one-bit delay
    @(posedge clk); f0 = nfr[0];
    send(24'h800001, 24'h7FFFFE, 200);
    wait_frames(f0 + 2);
    chk_frame("s1", 0, 32'h8000_0100, 32'h7FFF_FE00);
`ifndef SID_I2S_DITHER_EN
    chk_frame("s1", 1, 32'h8000_0000, 32'h7FFF_0000);
`endif

    // Truncation to 16 bits
    @(posedge clk); f0 = nfr[0];
    send(24'h12345F, 24'h0ABCDE, 200);
    wait_frames(f0 + 2);
    chk_frame("s2", 0, 32'h1234_5F00, 32'h0ABC_DE00);
`ifndef SID_I2S_DITHER_EN
    chk_frame("s2", 1, 32'h1234_0000, 32'h0ABC_0000);
`endif

    // Two samples in one frame: latest wins
    @(posedge clk); f0 = nfr[0];
    send(24'h111111, 24'h222222, 100);
    send(24'h333333, 24'hCCCCCC, 300);
    wait_frames(f0 + 2);
    chk_frame("s3", 0, 32'h3333_3300, 32'hCCCC_CC00);
`ifndef SID_I2S_DITHER_EN
    chk_frame("s3", 1, 32'h3333_0000, 32'hCCCC_0000);
`endif

    // Sample on the exact frame-load cycle
    @(posedge clk); f0 = nfr[0];
    send(24'h5A5A5A, 24'hA5A5A5, 200);
    send(24'h0F0F0F, 24'hF0F0F0, 7);
    wait_frames(f0 + 2);
    chk_frame("s4c", 0, 32'h5A5A_5A00, 32'hA5A5_A500);
`ifndef SID_I2S_DITHER_EN
    chk_frame("s4c", 1, 32'h5A5A_0000, 32'hA5A5_0000);
`endif
    wait_frames(f0 + 3);
    chk_frame("s4d", 0, 32'h0F0F_0F00, 32'hF0F0_F000);
`ifndef SID_I2S_DITHER_EN
    chk_frame("s4d", 1, 32'h0F0F_0000, 32'hF0F0_0000);
`endif

    // Idle frame retransmits the last sample with underrun
    wait_frames(f0 + 4);
    chk_frame("s5", 0, 32'h0F0F_0F00, 32'hF0F0_F000);
    chk("ovr_total", 0, 64'(novr[0]), 64'd1);
    chk("ovr_total", 1, 64'(novr[1]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sid_i2s_tx.md
Name: sid_i2s_tx

Overview:
- I2S transmitter directly downstream of the dual-SID API block.
- Captures each stereo filter output pair (signed 24-bit left/right) on a one-cycle strobe and double-buffers it.
- Serializes the pair to an external DAC as a standard Philips I2S frame: 64 BCLK per frame, 32-bit slots, MSB-first.
- BCLK and LRCLK are generated internally from `clk`.

Parameters:
- CLK_DIV, 4, clk cycles per BCLK half-period (≥2). BCLK period = 2*CLK_DIV clk.
- OUT_BITS, 24, transmitted bits per sample (16..24). MSB-aligned in the 32-bit slot; remaining slot bits are 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sample_valid  in  1  one-cycle strobe: left_i/right_i hold a new sample pair
- left_i  in  24  signed left sample
- right_i  in  24  signed right sample
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select (0 = left, 1 = right)
- i2s_sdata  out  1  serial data; changes on BCLK falling edge
- underrun  out  1  one-cycle pulse: frame started with no new sample
- overrun  out  1  one-cycle pulse: sample overwritten before transmission

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, underrun=0, overrun=0.
  - div_cnt=0, bit_cnt=63.
  - Holding register, frame shift register and `pending` flag all 0.
- Reset mid-frame aborts the frame immediately; the next frame is all-zero data.
- Divider:
  - div_cnt counts 0..CLK_DIV-1, wraps to 0.
  - At the terminal count i2s_bclk toggles.
  - A toggle to 0 is a "fall event".
- Fall event sequence:
  - bit_cnt increments modulo 64.
  - i2s_lrclk <= new bit_cnt[5].
  - i2s_sdata <= frame[63 - new bit_cnt].
- Frame load (fall event where bit_cnt wraps 63->0):
  - frame <= {1'b0, Lslot, Rslot[31:1]}, with Lslot/Rslot = {sample[23 -: OUT_BITS], zeros}.
  - Slot LSB is always 0, so truncating Rslot is lossless.
  - I2S one-bit delay: L MSB appears at bit_cnt=1; R MSB at bit_cnt=33.
  - Loaded from the holding register; pending <= 0.
  - If pending was 0: the previous holding contents are retransmitted and underrun pulses on that cycle.
- Holding register: on sample_valid, holds {left_i, right_i} (processed as per Optional Feature); pending <= 1.
  - If pending was already 1, the new sample replaces the old one (latest wins) and overrun pulses.
- Simultaneous sample_valid and frame load in the same cycle:
  - The frame takes the old holding contents.
  - pending ends at 1 (new sample queued for the next frame).
  - underrun follows the old pending value; no overrun.
- Latency: sample_valid to MSB on i2s_sdata is between 1 and 64 BCLK + 2*CLK_DIV clk. No back-pressure.
- Frame rate = clk / (128*CLK_DIV). Upstream must supply ≤1 sample per frame on average.

Optional Feature:
- Macro: SID_I2S_DITHER_EN.
- Defined, with OUT_BITS<24:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances once per sample_valid.
  - Its low (24-OUT_BITS) bits are added (unsigned) to each of left_i and right_i before loading the holding register.
  - Signed overflow saturates to 24'h7FFFFF.
  - The same LFSR value is used for both channels.
- Defined, with OUT_BITS=24: no effect.
- Undefined: plain truncation; no LFSR logic.

Test Plan:
- Reset, then idle with CLK_DIV=4 -> BCLK period 8 clk; LRCLK falls at first fall event and has period 512 clk; sdata all 0; underrun pulses once per frame.
- sample_valid with L=24'h800001, R=24'h7FFFFE, OUT_BITS=24 -> next frame: sdata after LRCLK falls is 0, then 100000000000000000000001, then eight 0s; right slot carries 011111111111111111111110 + zeros; no underrun.
- OUT_BITS=16, L=24'h12345F (dither off) -> left slot transmits 16'h1234 then 16 zeros.
- Two sample_valid pulses (A then B) inside one frame -> overrun pulses on B; next frame carries B only.
- sample_valid on the exact frame-load cycle -> current frame uses the old data; next frame carries the new sample; no underrun on that next frame.
- SID_I2S_DITHER_EN, OUT_BITS=16, L=24'h7FFFFF -> transmitted 16'h7FFF (saturated); L=24'h000000 with LFSR low byte 8'hFF -> 16'h0000.
